// File: rtl/move_pkg.sv
// Shared definitions for the move collector: flag field layout and FSM state encoding.
package move_pkg;

   localparam int FLAG_W = 7;
   localparam int SQ_W   = 6;

   // flag bit positions inside the flag field (field sits at the top of the move word)
   localparam int FLG_INVALID = 6;
   localparam int FLG_PROMOTE = 5;
   localparam int FLG_PAWN    = 4;
   localparam int FLG_PAWN2   = 3;
   localparam int FLG_EP      = 2;
   localparam int FLG_CASTLE  = 1;
   localparam int FLG_CAPTURE = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/move_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rd_data one cycle after it is written.
module move_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // a full FIFO refuses writes even if a read happens in the same cycle
   assign do_wr   = wr & ~full;
   assign do_rd   = rd & ~empty;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/move_collector.sv
// Round-robin drain of NCH per-square move FIFOs into one output FIFO.
// Optional MOVE_COLLECTOR_FILTER_EN: words flagged invalid are popped but not forwarded.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// SCAN  | looking for the next done, uncollected channel from rr_ptr
// DRAIN | popping channel ch until its source FIFO is empty
// DONE  | every channel collected; waits for start to re-arm
module move_collector
   import move_pkg::*;
#(
   parameter int NCH    = 8,
   parameter int MOVE_W = 19,
   parameter int DEPTH  = 64,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [NCH-1:0]           sq_done,
   input  logic [NCH-1:0]           sq_empty,
   input  logic [NCH*MOVE_W-1:0]    sq_data,
   output logic [NCH-1:0]           sq_rden,
   output logic [MOVE_W-1:0]        out_data,
   output logic                     out_empty,
   input  logic                     out_rden,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic [CNT_W-1:0]         move_total,
   output logic                     busy,
   output logic                     done
);

   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

   state_t            state, state_nx;
   logic [NCH-1:0]    collected, collected_nx;
   logic [CH_W-1:0]   rr_ptr, rr_nx;
   logic [CH_W-1:0]   ch, ch_nx;
   logic [CH_W-1:0]   pick;
   logic              found;
   logic              clear_total;
   logic              pop;
   logic              fifo_wr;
   logic              full;
   logic [MOVE_W-1:0] head;

   assign head = sq_data[ch*MOVE_W +: MOVE_W];

   // lowest offset from rr_ptr wins, so walk offsets downward and let the last hit stand
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NCH) idx = idx - NCH;
         if (sq_done[idx] && !collected[idx]) begin
            found = 1'b1;
            pick  = CH_W'(idx);
         end
      end
   end

   always_comb begin
      state_nx     = state;
      collected_nx = collected;
      rr_nx        = rr_ptr;
      ch_nx        = ch;
      clear_total  = 1'b0;
      pop          = 1'b0;
      sq_rden      = '0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx     = SCAN;
               collected_nx = '0;
               clear_total  = 1'b1;
            end
         end
         SCAN: begin
            if (&collected) begin
               state_nx = DONE;
            end else if (found) begin
               ch_nx    = pick;
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (sq_empty[ch]) begin
               collected_nx[ch] = 1'b1;
               rr_nx            = (ch == CH_W'(NCH - 1)) ? '0 : ch + 1'b1;
               state_nx         = SCAN;
            end else if (!full) begin
               pop         = 1'b1;
               sq_rden[ch] = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef MOVE_COLLECTOR_FILTER_EN
   localparam int INV_BIT = MOVE_W - FLAG_W + FLG_INVALID;
   assign fifo_wr = pop & ~head[INV_BIT];
`else
   assign fifo_wr = pop;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         collected  <= '0;
         rr_ptr     <= '0;
         ch         <= '0;
         move_total <= '0;
      end else begin
         state     <= state_nx;
         collected <= collected_nx;
         rr_ptr    <= rr_nx;
         ch        <= ch_nx;
         if (clear_total)
            move_total <= '0;
         else if (fifo_wr && (move_total != {CNT_W{1'b1}}))
            move_total <= move_total + 1'b1;
      end
   end

   assign busy = (state == SCAN) || (state == DRAIN);
   assign done = (state == DONE);

   move_fifo #(
      .WIDTH (MOVE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (fifo_wr),
      .wr_data (head),
      .rd      (out_rden),
      .rd_data (out_data),
      .empty   (out_empty),
      .full    (full),
      .count   (out_count)
   );

endmodule

// File: tb/tb_move_collector.sv
// Testbench for move_collector: queue-based source channels and an ordered output scoreboard.
module tb_move_collector;

   localparam int NCH    = 8;
   localparam int MOVE_W = 19;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 16;
   localparam int OCW    = $clog2(DEPTH) + 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [NCH-1:0]        sq_done;
   logic [NCH-1:0]        sq_empty = '1;
   logic [NCH*MOVE_W-1:0] sq_data  = '0;
   logic [NCH-1:0]        sq_rden;
   logic [MOVE_W-1:0]     out_data;
   logic                  out_empty;
   logic                  out_rden = 1'b0;
   logic [OCW-1:0]        out_count;
   logic [CNT_W-1:0]      move_total;
   logic                  busy;
   logic                  done;

   int checks = 0;
   int errors = 0;

   logic [MOVE_W-1:0] src_q [NCH][$];
   logic [MOVE_W-1:0] exp_q [$];
   int                pop_cnt [NCH];
   int                cons_mode = 0;   // 0 off, 1 always read, 2 random
   int                exp_rr = 0;

   move_collector #(
      .NCH(NCH), .MOVE_W(MOVE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .sq_done(sq_done),
      .sq_empty(sq_empty), .sq_data(sq_data), .sq_rden(sq_rden),
      .out_data(out_data), .out_empty(out_empty), .out_rden(out_rden),
      .out_count(out_count), .move_total(move_total), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // source/consumer model: sample at negedge, act 2 time units after posedge
   logic [NCH-1:0]    s_rden, s_empty;
   logic              s_ord, s_oe, s_rst;
   logic [MOVE_W-1:0] s_od, exp_w;
   always begin
      @(negedge clk);
      s_rden = sq_rden; s_empty = sq_empty; s_ord = out_rden;
      s_oe = out_empty; s_od = out_data; s_rst = reset;
      @(posedge clk);
      #2;
      if (s_rst && s_ord && !s_oe) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got word %h, expected none", s_od);
         end else begin
            exp_w = exp_q.pop_front();
            if (s_od !== exp_w) begin
               errors++;
               $display("FAIL sb_order: got %h, expected %h", s_od, exp_w);
            end
         end
      end
      checks++;
      if (!$onehot0(s_rden) || ((s_rden & s_empty) != '0)) begin
         errors++;
         $display("FAIL rden_legal: sq_rden=%b sq_empty=%b, expected one-hot-or-zero on non-empty", s_rden, s_empty);
      end
      for (int i = 0; i < NCH; i++) begin
         if (s_rden[i] && src_q[i].size() != 0) begin
            void'(src_q[i].pop_front());
            pop_cnt[i]++;
         end
      end
      for (int i = 0; i < NCH; i++) begin
         sq_empty[i] = (src_q[i].size() == 0);
         sq_data[i*MOVE_W +: MOVE_W] = (src_q[i].size() == 0) ? '0 : src_q[i][0];
      end
      case (cons_mode)
         0:       out_rden = 1'b0;
         1:       out_rden = 1'b1;
         default: out_rden = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [MOVE_W-1:0] gen_word(input bit allow_inv);
      logic [MOVE_W-1:0] w;
      w = MOVE_W'($urandom);
      w[MOVE_W-1] = allow_inv ? ($urandom_range(0, 3) == 0) : 1'b0;
      return w;
   endfunction

   function automatic bit kept(input logic [MOVE_W-1:0] w);
`ifdef MOVE_COLLECTOR_FILTER_EN
      return !w[MOVE_W-1];
`else
      return 1'b1;
`endif
   endfunction

   task automatic add_expect_ch(input int c, inout int cnt);
      foreach (src_q[c][j]) begin
         if (kept(src_q[c][j])) begin
            exp_q.push_back(src_q[c][j]);
            cnt++;
         end
      end
   endtask

   task automatic build_expect(input int first, output int cnt);
      cnt = 0;
      for (int k = 0; k < NCH; k++) add_expect_ch((first + k) % NCH, cnt);
   endtask

   task automatic clear_sources();
      for (int i = 0; i < NCH; i++) begin
         src_q[i].delete();
         pop_cnt[i] = 0;
      end
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_out_empty(input int budget, output int cyc);
      cyc = 0;
      while (!out_empty && cyc < budget) begin
         tick();
         cyc++;
      end
      tick(2);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(3);
      reset = 1'b1;
      tick();
      checks++;
      if (out_empty !== 1'b1 || out_count !== '0 || done !== 1'b0 || busy !== 1'b0 ||
          sq_rden !== '0 || move_total !== '0) begin
         errors++;
         $display("FAIL reset_state: empty=%b count=%0d done=%b busy=%b rden=%b total=%0d, expected 1 0 0 0 0 0",
                  out_empty, out_count, done, busy, sq_rden, move_total);
      end
   endtask

   task automatic test_basic();
      int n, cyc;
      clear_sources();
      for (int j = 0; j < 3; j++) src_q[2].push_back(gen_word(0));
      src_q[5].push_back(gen_word(0));
      build_expect(exp_rr, n);
      sq_done = '1;
      cons_mode = 0;
      tick(2);
      pulse_start();
      wait_done(100, cyc);
      checks++;
      if (!done || cyc + 1 > 24) begin
         errors++;
         $display("FAIL basic_done_time: done=%b after %0d cycles, expected done within 24", done, cyc + 1);
      end
      checks++;
      if (move_total !== CNT_W'(4) || out_count !== OCW'(4)) begin
         errors++;
         $display("FAIL basic_total: move_total=%0d out_count=%0d, expected 4 4", move_total, out_count);
      end
      tick(3);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_hold: done=%b busy=%b, expected 1 0", done, busy);
      end
      cons_mode = 1;
      wait_out_empty(50, cyc);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_drain: %0d words left unread, expected 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      int n, cyc;
      clear_sources();
      for (int j = 0; j < 6; j++) src_q[0].push_back(gen_word(0));
      build_expect(exp_rr, n);
      sq_done = '1;
      cons_mode = 0;
      tick(2);
      pulse_start();
      cyc = 0;
      while (out_count != OCW'(DEPTH) && cyc < 100) begin
         tick();
         cyc++;
      end
      tick(3);
      checks++;
      if (out_count !== OCW'(DEPTH) || sq_rden !== '0 || src_q[0].size() != 2) begin
         errors++;
         $display("FAIL bp_full: count=%0d rden=%b src_left=%0d, expected %0d 0 2",
                  out_count, sq_rden, src_q[0].size(), DEPTH);
      end
      cons_mode = 1;
      tick();
      cons_mode = 0;
      tick(4);
      checks++;
      if (src_q[0].size() != 1 || pop_cnt[0] != 5 || out_count !== OCW'(DEPTH)) begin
         errors++;
         $display("FAIL bp_one_pop: src_left=%0d pops=%0d count=%0d, expected 1 5 %0d",
                  src_q[0].size(), pop_cnt[0], out_count, DEPTH);
      end
      cons_mode = 1;
      wait_done(200, cyc);
      wait_out_empty(50, cyc);
      checks++;
      if (!done || move_total !== CNT_W'(n) || pop_cnt[0] != 6 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_complete: done=%b total=%0d pops=%0d left=%0d, expected 1 %0d 6 0",
                  done, move_total, pop_cnt[0], exp_q.size(), n);
      end
   endtask

   task automatic test_rr_order();
      int n, cyc;
      clear_sources();
      for (int j = 0; j < 2; j++) src_q[7].push_back(gen_word(0));
      for (int j = 0; j < 2; j++) src_q[1].push_back(gen_word(0));
      n = 0;
      add_expect_ch(7, n);
      add_expect_ch(1, n);
      sq_done = '0;
      cons_mode = 1;
      tick(2);
      pulse_start();
      tick(3);
      checks++;
      if (busy !== 1'b1 || sq_rden !== '0) begin
         errors++;
         $display("FAIL scan_wait: busy=%b rden=%b, expected 1 0", busy, sq_rden);
      end
      pulse_start();
      tick(2);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || move_total !== '0) begin
         errors++;
         $display("FAIL start_ignored: busy=%b done=%b total=%0d, expected 1 0 0", busy, done, move_total);
      end
      sq_done[7] = 1'b1;
      tick();
      sq_done[1] = 1'b1;
      cyc = 0;
      while (pop_cnt[7] != 2 && cyc < 50) begin
         tick();
         cyc++;
      end
      checks++;
      if (pop_cnt[7] != 2 || pop_cnt[1] != 0) begin
         errors++;
         $display("FAIL rr_first: pops ch7=%0d ch1=%0d, expected 2 0", pop_cnt[7], pop_cnt[1]);
      end
      cyc = 0;
      while (pop_cnt[1] != 2 && cyc < 50) begin
         tick();
         cyc++;
      end
      tick(4);
      checks++;
      if (pop_cnt[1] != 2 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL rr_wrap: pops ch1=%0d busy=%b done=%b, expected 2 1 0", pop_cnt[1], busy, done);
      end
      sq_done = '1;
      wait_done(200, cyc);
      wait_out_empty(50, cyc);
      checks++;
      if (!done || move_total !== CNT_W'(n) || exp_q.size() != 0) begin
         errors++;
         $display("FAIL rr_complete: done=%b total=%0d left=%0d, expected 1 %0d 0", done, move_total, exp_q.size(), n);
      end
      // channels 2..6 then 0 were drained last, so the pointer ends just past channel 0
      exp_rr = 1;
   endtask

   task automatic test_random();
      int n, cyc;
      for (int p = 0; p < 4; p++) begin
         clear_sources();
         for (int i = 0; i < NCH; i++) begin
            int len;
            len = $urandom_range(0, 4);
            for (int j = 0; j < len; j++) src_q[i].push_back(gen_word(1));
         end
         build_expect(exp_rr, n);
         sq_done = '1;
         cons_mode = 2;
         tick(2);
         pulse_start();
         wait_done(2000, cyc);
         checks++;
         if (!done || move_total !== CNT_W'(n)) begin
            errors++;
            $display("FAIL rand_pass%0d: done=%b total=%0d, expected 1 %0d", p, done, move_total, n);
         end
         cons_mode = 1;
         wait_out_empty(50, cyc);
         checks++;
         if (exp_q.size() != 0 || out_count !== '0) begin
            errors++;
            $display("FAIL rand_drain%0d: left=%0d count=%0d, expected 0 0", p, exp_q.size(), out_count);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n, cyc;
      clear_sources();
      for (int j = 0; j < 8; j++) src_q[0].push_back(gen_word(0));
      build_expect(exp_rr, n);
      sq_done = '1;
      cons_mode = 0;
      tick(2);
      pulse_start();
      cyc = 0;
      while (out_count != OCW'(3) && cyc < 100) begin
         tick();
         cyc++;
      end
      checks++;
      if (out_count !== OCW'(3) || busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup: count=%0d busy=%b, expected 3 1", out_count, busy);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (out_count !== '0 || out_empty !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          sq_rden !== '0 || move_total !== '0) begin
         errors++;
         $display("FAIL mid_reset: count=%0d empty=%b busy=%b done=%b rden=%b total=%0d, expected 0 1 0 0 0 0",
                  out_count, out_empty, busy, done, sq_rden, move_total);
      end
      reset = 1'b1;
      exp_q.delete();
      clear_sources();
      exp_rr = 0;
      for (int j = 0; j < 3; j++) src_q[4].push_back(gen_word(1));
      src_q[6].push_back(gen_word(1));
      build_expect(exp_rr, n);
      cons_mode = 1;
      tick(2);
      pulse_start();
      wait_done(200, cyc);
      wait_out_empty(50, cyc);
      checks++;
      if (!done || move_total !== CNT_W'(n) || exp_q.size() != 0 || pop_cnt[4] != 3) begin
         errors++;
         $display("FAIL mid_clean_pass: done=%b total=%0d left=%0d pops4=%0d, expected 1 %0d 0 3",
                  done, move_total, exp_q.size(), pop_cnt[4], n);
      end
   endtask

   task automatic test_filter();
      int n, cyc, want;
      logic [MOVE_W-1:0] w;
      clear_sources();
      w = MOVE_W'(32'h00123); src_q[3].push_back(w);
      w = MOVE_W'(32'h40456); src_q[3].push_back(w);
      w = MOVE_W'(32'h00789); src_q[3].push_back(w);
      build_expect(exp_rr, n);
`ifdef MOVE_COLLECTOR_FILTER_EN
      want = 2;
`else
      want = 3;
`endif
      sq_done = '1;
      cons_mode = 1;
      tick(2);
      pulse_start();
      wait_done(200, cyc);
      wait_out_empty(50, cyc);
      checks++;
      if (pop_cnt[3] != 3 || move_total !== CNT_W'(want) || exp_q.size() != 0 || !done) begin
         errors++;
         $display("FAIL filter: pops=%0d total=%0d left=%0d done=%b, expected 3 %0d 0 1",
                  pop_cnt[3], move_total, exp_q.size(), done, want);
      end
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      sq_done = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_rr_order();
      test_random();
      test_reset_mid();
      test_filter();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/move_collector.md
Name: move_collector

Overview:
Parametrised successor to the per-column move gatherer. It drains NCH per-square move FIFOs into one shared output FIFO using round-robin arbitration. It applies backpressure when the output FIFO is full and can be re-armed by a start pulse without a reset. It sits between a bank of square generators (one channel per square) and the board-level move consumer; MOVE_W and NCH cover column (8), half-board (32) or full-board (64) use.

Parameters:
NCH, 8, number of square channels (2..64)
MOVE_W, 19, move word width; format [MOVE_W-1 -: 7] flags {invalid,promote,pawn,pawn2,ep,castle,capture}, then 6b from, 6b to
DEPTH, 64, output FIFO depth in words (power of 2, >=4)
CNT_W, 16, width of move_total counter

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse; arms a collection pass
sq_done  in  NCH  channel i has finished generating; stays high until the next pass
sq_empty  in  NCH  channel i source FIFO empty
sq_data  in  NCH*MOVE_W  channel i head word at [i*MOVE_W +: MOVE_W]; show-ahead, valid when ~sq_empty[i]
sq_rden  out  NCH  pop strobe to channel i (combinational, one-hot or zero)
out_data  out  MOVE_W  output FIFO head word (show-ahead)
out_empty  out  1  output FIFO empty
out_rden  in  1  consumer pop
out_count  out  $clog2(DEPTH)+1  words held
move_total  out  CNT_W  words written this pass (saturating)
busy  out  1  state is SCAN or DRAIN
done  out  1  state is DONE

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; collected flags = 0; rr_ptr = 0; output FIFO flushed. Reset values: out_empty=1, out_count=0, move_total=0, busy=0, done=0, sq_rden=0. Reset mid-pass aborts the pass and discards all buffered words.
- States:
  - IDLE: on start -> SCAN; clear collected flags and move_total.
  - SCAN: pick the first i at or after rr_ptr (wrapping modulo NCH) with sq_done[i] & ~collected[i]; latch ch=i, go to DRAIN next cycle. If all collected flags are set -> DONE. If nothing is eligible, stay in SCAN.
  - DRAIN: sq_rden[ch] = ~sq_empty[ch] & ~full. A popped word is written to the output FIFO the same edge and move_total increments (saturating at all-ones). If sq_empty[ch]: set collected[ch], rr_ptr = ch+1 (wrap to 0 at NCH), -> SCAN.
  - DONE: holds until start (-> SCAN, flags and move_total cleared) or reset. out FIFO contents are kept across start.
- start in SCAN or DRAIN is ignored.
- Only one channel is drained at a time. A channel that is empty but done is marked collected after one DRAIN cycle with no pop.
- Output FIFO:
  - Write-to-visible latency is 1 cycle: a word popped at edge k is on out_data after edge k.
  - Full blocks writes even when out_rden is asserted in the same cycle.
  - out_rden while empty is ignored.
  - A simultaneous read and write while non-full and non-empty leaves out_count unchanged.
  - Pointers wrap modulo DEPTH.
- Throughput: 1 word/cycle while draining. Each channel switch costs 2 cycles (the empty-detect cycle plus the SCAN cycle).

Optional Feature:
MOVE_COLLECTOR_FILTER_EN:
- Defined: a source word with flag bit MOVE_W-1 (invalid) set is still popped (sq_rden asserted) but is not written to the output FIFO, and move_total does not increment. When full, invalid words are also not popped (backpressure rule unchanged).
- Undefined: every popped word is written. Ports are identical in both builds.

Decomposition:
- Shared package move_pkg:
  - flag bit indices (FLG_INVALID=6 ... FLG_CAPTURE=0 relative to the flag field)
  - field widths (FLAG_W=7, SQ_W=6)
  - state encoding localparams IDLE/SCAN/DRAIN/DONE
- Sub-module move_fifo (params WIDTH, DEPTH): synchronous show-ahead FIFO with wr, rd, empty, full and count, reset via the same active-low synchronous reset. The collector instantiates one.

Test Plan:
- Reset held 0 for 3 cycles, then released -> out_empty=1, out_count=0, done=0, busy=0, sq_rden=0.
- NCH=8; ch2 holds 3 words and ch5 holds 1; all sq_done=1; start pulse -> out_data order is ch2 w0,w1,w2 then ch5 w0; move_total=4; done asserted within 8+2*8 cycles of start.
- DEPTH=4, ch0 holds 6 words, out_rden=0 -> 4 words accepted, sq_rden[0] drops to 0 while full. Then out_rden=1 for 1 cycle -> exactly one more pop occurs; no word is lost or duplicated.
- sq_done rises in order 7, then 1, 1 cycle apart, starting from rr_ptr=0 -> ch7 drained first; after ch7 is collected, rr_ptr wraps to 0 and ch1 is drained next.
- Reset asserted mid-DRAIN with 3 words buffered -> next cycle out_count=0, state IDLE; a following start performs a clean pass.
- FILTER_EN build: ch3 words {valid 0x00123, invalid 0x40456, valid 0x00789} -> out receives 0x00123 and 0x00789 only; move_total=2; sq_rden[3] pulses 3 times. Without the macro all 3 words are written and move_total=3.
